// File: rtl/display_share_arbiter_if.sv
// Bundles the requester inputs and the display/grant outputs of the
// display share arbiter. The arbiter uses the slave view; whoever drives
// requests and watches grants (bench or surrounding logic) uses master.
interface display_share_arbiter_if;
  logic [2:0] i_Req;
  logic [7:0] i_Byte0;
  logic [7:0] i_Byte1;
  logic [7:0] i_Byte2;
  logic [2:0] o_Grant;
  logic       o_Busy;
  logic       o_NewGrant;
  logic [7:0] o_CharA;
  logic [7:0] o_CharB;

  modport master (
    output i_Req, i_Byte0, i_Byte1, i_Byte2,
    input  o_Grant, o_Busy, o_NewGrant, o_CharA, o_CharB
  );

  modport slave (
    input  i_Req, i_Byte0, i_Byte1, i_Byte2,
    output o_Grant, o_Busy, o_NewGrant, o_CharA, o_CharB
  );
endinterface

// File: rtl/display_share_arbiter.sv
// Round-robin arbiter sharing a two-digit display between three byte
// producers. Each owner keeps the display for at least HOLD_CYCLES clocks,
// then one CHECK cycle decides whether to hand over, renew or go idle.
// The granted byte is shown as two ASCII hex characters; idle shows "--".
module display_share_arbiter #(
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  display_share_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  localparam logic [7:0] CHAR_DASH = 8'h2D;

  logic [1:0]       r_State;
  logic [2:0]       r_Grant;
  logic [1:0]       r_Owner;
  logic [1:0]       r_Ptr;
  logic [CNT_W-1:0] r_Cnt;
  logic [7:0]       r_Byte;
  logic             r_Busy;
  logic             r_NewGrant;
  logic [7:0]       r_CharA;
  logic [7:0]       r_CharB;

  logic [2:0]       w_SearchReq;
  logic             w_Found;
  logic [1:0]       w_PickIdx;
  logic [7:0]       w_PickByte;
  logic [7:0]       w_OwnerByte;
  logic             w_OwnerReq;

  logic [1:0]       w_NState;
  logic [2:0]       w_NGrant;
  logic [1:0]       w_NOwner;
  logic [1:0]       w_NPtr;
  logic [CNT_W-1:0] w_NCnt;
  logic [7:0]       w_NByte;
  logic             w_NNew;

  // (p + k) mod 3 for p in 0..2 and k in 0..2
  function automatic logic [1:0] f_wrap(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  // One nibble to ASCII '0'-'9' / 'A'-'F'
  function automatic logic [7:0] f_hex(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // In CHECK the current owner is excluded so a waiting requester preempts it
  assign w_SearchReq = (r_State == S_CHECK) ? (bus.i_Req & ~r_Grant) : bus.i_Req;
  assign w_OwnerReq  = bus.i_Req[r_Owner];

  // Round-robin search: pointer, pointer+1, pointer+2
  always_comb begin
    w_Found   = 1'b0;
    w_PickIdx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!w_Found && w_SearchReq[f_wrap(r_Ptr, k)]) begin
        w_Found   = 1'b1;
        w_PickIdx = f_wrap(r_Ptr, k);
      end
    end
  end

  // Byte of the requester being picked and of the current owner
  always_comb begin
    case (w_PickIdx)
      2'd1:    w_PickByte = bus.i_Byte1;
      2'd2:    w_PickByte = bus.i_Byte2;
      default: w_PickByte = bus.i_Byte0;
    endcase
    case (r_Owner)
      2'd1:    w_OwnerByte = bus.i_Byte1;
      2'd2:    w_OwnerByte = bus.i_Byte2;
      default: w_OwnerByte = bus.i_Byte0;
    endcase
  end

  // Next-state logic for the IDLE / HOLD / CHECK controller
  always_comb begin
    w_NState = r_State;
    w_NGrant = r_Grant;
    w_NOwner = r_Owner;
    w_NPtr   = r_Ptr;
    w_NCnt   = r_Cnt;
    w_NByte  = r_Byte;
    w_NNew   = 1'b0;
    case (r_State)
      S_HOLD: begin
        w_NCnt = r_Cnt + CNT_W'(1);
        if (w_OwnerReq) w_NByte = w_OwnerByte;
        if (r_Cnt == CNT_LAST) w_NState = S_CHECK;
      end
      S_CHECK: begin
        if (w_Found) begin
          w_NState = S_HOLD;
          w_NGrant = 3'b001 << w_PickIdx;
          w_NOwner = w_PickIdx;
          w_NPtr   = f_wrap(w_PickIdx, 1);
          w_NCnt   = '0;
          w_NByte  = w_PickByte;
          w_NNew   = 1'b1;
        end else if (w_OwnerReq) begin
          w_NState = S_HOLD;
          w_NCnt   = '0;
          w_NByte  = w_OwnerByte;
        end else begin
          w_NState = S_IDLE;
          w_NGrant = 3'b000;
        end
      end
      default: begin
        if (w_Found) begin
          w_NState = S_HOLD;
          w_NGrant = 3'b001 << w_PickIdx;
          w_NOwner = w_PickIdx;
          w_NPtr   = f_wrap(w_PickIdx, 1);
          w_NCnt   = '0;
          w_NByte  = w_PickByte;
          w_NNew   = 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs; characters come from the next byte so
  // they change on the same edge as the grant
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State    <= S_IDLE;
      r_Grant    <= 3'b000;
      r_Owner    <= 2'd0;
      r_Ptr      <= 2'd0;
      r_Cnt      <= '0;
      r_Byte     <= 8'h00;
      r_Busy     <= 1'b0;
      r_NewGrant <= 1'b0;
      r_CharA    <= CHAR_DASH;
      r_CharB    <= CHAR_DASH;
    end else begin
      r_State    <= w_NState;
      r_Grant    <= w_NGrant;
      r_Owner    <= w_NOwner;
      r_Ptr      <= w_NPtr;
      r_Cnt      <= w_NCnt;
      r_Byte     <= w_NByte;
      r_Busy     <= |w_NGrant;
      r_NewGrant <= w_NNew;
      r_CharA    <= (|w_NGrant) ? f_hex(w_NByte[7:4]) : CHAR_DASH;
      r_CharB    <= (|w_NGrant) ? f_hex(w_NByte[3:0]) : CHAR_DASH;
    end
  end

  assign bus.o_Grant    = r_Grant;
  assign bus.o_Busy     = r_Busy;
  assign bus.o_NewGrant = r_NewGrant;
  assign bus.o_CharA    = r_CharA;
  assign bus.o_CharB    = r_CharB;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter with HOLD_CYCLES=4. Expected output words
// {grant, busy, newgrant, charA, charB} are queued as stimulus is applied
// and popped after each rising edge.
module tb_display_share_arbiter;

  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  display_share_arbiter_if bus();

  display_share_arbiter #(.HOLD_CYCLES(H)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [20:0] sb[$];
  logic [20:0] e;
  string hexs = "0123456789ABCDEF";

  function automatic logic [20:0] f_exp(input logic [2:0] g, input logic ng,
                                        input logic [7:0] b);
    logic [7:0] ca;
    logic [7:0] cb;
    if (g == 3'b000) begin
      ca = 8'h2D;
      cb = 8'h2D;
    end else begin
      ca = hexs[int'(b[7:4])];
      cb = hexs[int'(b[3:0])];
    end
    return {g, |g, ng, ca, cb};
  endfunction

  function automatic logic [20:0] f_obs();
    return {bus.o_Grant, bus.o_Busy, bus.o_NewGrant, bus.o_CharA, bus.o_CharB};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_Req = 3'b000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Req = 3'b000;
    bus.i_Byte0 = 8'h12; bus.i_Byte1 = 8'h34; bus.i_Byte2 = 8'h56;
    sb.push_back(f_exp(3'b000, 1'b0, 8'h00));
    tick();
    e = sb.pop_front(); n_chk++;
    if (f_obs() !== e) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", f_obs(), e);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sb.push_back(f_exp(3'b000, 1'b0, 8'h00));
      tick();
      e = sb.pop_front(); n_chk++;
      if (f_obs() !== e) begin
        n_fail++; $display("FAIL idle_no_req cyc%0d: got %h want %h", i, f_obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    bus.i_Byte0 = 8'h5A;
    bus.i_Req = 3'b001;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst = 1'b1;
      if (i == 3) begin rst = 1'b0; bus.i_Req = 3'b000; end
      if (i < 2) sb.push_back(f_exp(3'b001, i == 0, 8'h5A));
      else       sb.push_back(f_exp(3'b000, 1'b0, 8'h00));
      tick();
      e = sb.pop_front(); n_chk++;
      if (f_obs() !== e) begin
        n_fail++; $display("FAIL reset_mid_hold cyc%0d: got %h want %h", i, f_obs(), e);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.i_Byte1 = 8'h3C;
    bus.i_Req = 3'b010;
    for (int i = 0; i < 30; i++) begin
      sb.push_back(f_exp(3'b010, i == 0, 8'h3C));
      tick();
      e = sb.pop_front(); n_chk++;
      if (f_obs() !== e) begin
        n_fail++; $display("FAIL single_req1 cyc%0d: got %h want %h", i, f_obs(), e);
      end
    end
    n_chk++;
    if (bus.o_CharA !== 8'h33 || bus.o_CharB !== 8'h43) begin
      n_fail++; $display("FAIL single_chars: got %h/%h want 33/43", bus.o_CharA, bus.o_CharB);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] bytes [3];
    int owner;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    do_reset();
    bus.i_Byte0 = bytes[0]; bus.i_Byte1 = bytes[1]; bus.i_Byte2 = bytes[2];
    bus.i_Req = 3'b111;
    for (int i = 0; i < 16; i++) begin
      owner = (i / (H + 1)) % 3;
      sb.push_back(f_exp(3'b001 << owner, (i % (H + 1)) == 0, bytes[owner]));
      tick();
      e = sb.pop_front(); n_chk++;
      if (f_obs() !== e) begin
        n_fail++; $display("FAIL rotate cyc%0d: got %h want %h", i, f_obs(), e);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.i_Byte0 = 8'hA5;
    bus.i_Req = 3'b001;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin bus.i_Req = 3'b000; bus.i_Byte0 = 8'h77; end
      if (i < 5) sb.push_back(f_exp(3'b001, i == 0, 8'hA5));
      else       sb.push_back(f_exp(3'b000, 1'b0, 8'h00));
      tick();
      e = sb.pop_front(); n_chk++;
      if (f_obs() !== e) begin
        n_fail++; $display("FAIL drop_freeze cyc%0d: got %h want %h", i, f_obs(), e);
      end
    end
  endtask

  task automatic test_nibbles();
    logic [7:0] seq [4];
    logic [7:0] b;
    seq[0] = 8'h09; seq[1] = 8'h0A; seq[2] = 8'h9F; seq[3] = 8'hFF;
    do_reset();
    bus.i_Req = 3'b001;
    for (int i = 0; i < 8; i++) begin
      b = seq[i / 2];
      bus.i_Byte0 = b;
      sb.push_back(f_exp(3'b001, i == 0, b));
      tick();
      e = sb.pop_front(); n_chk++;
      if (f_obs() !== e) begin
        n_fail++; $display("FAIL nibble %h cyc%0d: got %h want %h", b, i, f_obs(), e);
      end
    end
  endtask

  task automatic test_check_arrival();
    do_reset();
    bus.i_Byte0 = 8'h41; bus.i_Byte2 = 8'hC7;
    bus.i_Req = 3'b001;
    for (int i = 0; i < 12; i++) begin
      if (i == H + 1) bus.i_Req = 3'b101;
      if (i <= H)                sb.push_back(f_exp(3'b001, i == 0, 8'h41));
      else if (i <= 2 * H + 1)   sb.push_back(f_exp(3'b100, i == H + 1, 8'hC7));
      else                       sb.push_back(f_exp(3'b001, i == 2 * H + 2, 8'h41));
      tick();
      e = sb.pop_front(); n_chk++;
      if (f_obs() !== e) begin
        n_fail++; $display("FAIL check_arrival cyc%0d: got %h want %h", i, f_obs(), e);
      end
    end
  endtask

  initial begin
    bus.i_Req = 3'b000;
    bus.i_Byte0 = 8'h00; bus.i_Byte1 = 8'h00; bus.i_Byte2 = 8'h00;
    #1;
    test_reset();
    test_reset_mid_hold();
    test_single();
    test_rotate();
    test_drop();
    test_nibbles();
    test_check_arrival();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
